// File: rtl/gen3_rx_pkg.sv
// Shared Gen3 receive-path constants, the DLLP payload type and the DLLP CRC16 helper.
package gen3_rx_pkg;

  localparam logic [7:0]  SDP_TOKEN0         = 8'hF0;
  localparam logic [7:0]  SDP_TOKEN1         = 8'hAC;
  localparam int unsigned DLLP_BYTES         = 8;
  localparam int unsigned DLLP_PAYLOAD_BYTES = 6;
  localparam logic [15:0] DLLP_CRC_POLY      = 16'h100B;
  localparam logic [15:0] DLLP_CRC_SEED      = 16'hFFFF;

  // DLLP bytes 0..5 without the SDP token; body[7:0] is byte 0, crc[7:0] is byte 4.
  typedef struct packed {
    logic [15:0] crc;
    logic [31:0] body;
  } dllp_t;

  // Bits enter LSB-first per byte; the complemented remainder is bit-reversed into bytes 4..5.
  function automatic logic [15:0] crc16_dllp(input logic [31:0] body);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = DLLP_CRC_SEED;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ body[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ DLLP_CRC_POLY;
    end
    c = ~c;
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return r;
  endfunction

endpackage

// File: rtl/gen3_dllp_fifo.sv
// DLLP queue: writes a whole group of up to LANES/8 entries in one cycle (or drops it), reads one.
module gen3_dllp_fifo
  import gen3_rx_pkg::*;
#(
  parameter int unsigned LANES      = 64,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [$clog2(LANES/DLLP_BYTES):0]       wr_cnt,
  input  dllp_t [LANES/DLLP_BYTES-1:0]            wr_data,
  input  logic                                    rd_ready,
  output logic                                    rd_valid,
  output dllp_t                                   rd_data,
  output logic [$clog2(FIFO_DEPTH):0]             level,
  output logic                                    overflow
);

  localparam int unsigned NSLOT = LANES / DLLP_BYTES;
  localparam int unsigned CW    = $clog2(NSLOT) + 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;

  dllp_t          mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  free_c;
  logic [LW-1:0]  level_nxt;
  logic [LW-1:0]  head_left;
  logic [AW-1:0]  head_ptr;
  logic           push_c;
  logic           drop_c;
  logic           pop_c;

  // Space is judged against the level before this cycle's pop.
  always_comb begin
    free_c    = LW'(FIFO_DEPTH) - level;
    push_c    = (wr_cnt != '0) && (LW'(wr_cnt) <= free_c);
    drop_c    = (wr_cnt != '0) && !push_c;
    pop_c     = rd_valid && rd_ready;
    level_nxt = level + (push_c ? LW'(wr_cnt) : '0) - LW'(pop_c);
    head_ptr  = rd_ptr + AW'(pop_c);
    head_left = level - LW'(pop_c);
  end

  // The output register presents the head one cycle after it lands in memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (push_c && (CW'(i) < wr_cnt)) mem[wr_ptr + AW'(i)] <= wr_data[i];
      end
      if (push_c) wr_ptr <= wr_ptr + AW'(wr_cnt);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (drop_c) overflow <= 1'b1;
      level    <= level_nxt;
      rd_valid <= (head_left != '0);
      rd_data  <= mem[head_ptr];
    end
  end

endmodule

// File: rtl/gen3_dllp_extractor.sv
// Extracts SDP-framed DLLPs (including beat-straddling ones) and queues them for the link layer.
// Build option GEN3_DLLP_CRC_CHECK_EN adds the DLLP CRC16 check and the crc_err pulse.
module gen3_dllp_extractor
  import gen3_rx_pkg::*;
#(
  parameter int unsigned LANES      = 64,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*LANES-1:0]            data_in,
  input  logic [LANES-1:0]              valid_in,
  input  logic [LANES-1:0]              dlpstart,
  input  logic [LANES-1:0]              dlpend,
  output logic                          dllp_valid,
  input  logic                          dllp_ready,
  output dllp_t                         dllp_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          framing_err,
  output logic                          crc_err
);

  localparam int unsigned NSLOT = LANES / DLLP_BYTES;
  localparam int unsigned CW    = $clog2(NSLOT) + 1;
  localparam int unsigned SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned TAIL  = DLLP_BYTES - 1;
  localparam int unsigned PW    = 8 * DLLP_PAYLOAD_BYTES;

  logic [8*TAIL-1:0]            tail_data;
  logic [TAIL-1:0]              tail_valid;
  logic [TAIL-1:0]              tail_start;
  logic [8*(LANES+TAIL)-1:0]    win_data;
  logic [LANES+TAIL-1:0]        win_valid;
  logic [LANES+TAIL-1:0]        win_start;
  logic [CW-1:0]                ext_cnt;
  dllp_t [NSLOT-1:0]            ext_data;
  logic                         ext_ferr;
  logic [CW-1:0]                stg_cnt;
  dllp_t [NSLOT-1:0]            stg_data;
`ifdef GEN3_DLLP_CRC_CHECK_EN
  logic                         ext_cerr;
`endif

  // Window index i holds byte i-TAIL of the beat, so indices 0..TAIL-1 are the previous beat's tail.
  assign win_data  = {data_in, tail_data};
  assign win_valid = {valid_in, tail_valid};
  assign win_start = {dlpstart, tail_start};

  // For an end at lane e, the DLLP occupies window indices e..e+7; compact good ones in lane order.
  always_comb begin
    int unsigned             n;
    logic [8*DLLP_BYTES-1:0] cand;
    dllp_t                   pay;
    logic                    ok;
    n        = 0;
    cand     = '0;
    pay      = '0;
    ok       = 1'b0;
    ext_data = '0;
    ext_ferr = 1'b0;
`ifdef GEN3_DLLP_CRC_CHECK_EN
    ext_cerr = 1'b0;
`endif
    for (int e = 0; e < LANES; e++) begin
      cand = win_data[8*e +: 8*DLLP_BYTES];
      pay  = dllp_t'(cand[8*DLLP_BYTES-1 -: PW]);
      ok   = (&win_valid[e +: DLLP_BYTES]) && win_start[e] &&
             (cand[7:0] == SDP_TOKEN0) && (cand[15:8] == SDP_TOKEN1);
      if (dlpend[e] && valid_in[e]) begin
        if (!ok) begin
          ext_ferr = 1'b1;
`ifdef GEN3_DLLP_CRC_CHECK_EN
        end else if (crc16_dllp(pay.body) != pay.crc) begin
          ext_cerr = 1'b1;
`endif
        end else if (n < NSLOT) begin
          ext_data[SW'(n)] = pay;
          n++;
        end else begin
          ext_ferr = 1'b1;
        end
      end
    end
    ext_cnt = CW'(n);
  end

  // Stage 1: tail capture plus the compacted group and its error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail_data   <= '0;
      tail_valid  <= '0;
      tail_start  <= '0;
      stg_cnt     <= '0;
      stg_data    <= '0;
      framing_err <= 1'b0;
    end else begin
      if (|valid_in) begin
        tail_data  <= data_in[8*LANES-1 -: 8*TAIL];
        tail_valid <= valid_in[LANES-1 -: TAIL];
        tail_start <= dlpstart[LANES-1 -: TAIL];
      end
      stg_cnt     <= ext_cnt;
      stg_data    <= ext_data;
      framing_err <= ext_ferr;
    end
  end

`ifdef GEN3_DLLP_CRC_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_err <= 1'b0;
    else      crc_err <= ext_cerr;
  end
`else
  assign crc_err = 1'b0;
`endif

  gen3_dllp_fifo #(
    .LANES      (LANES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_cnt   (stg_cnt),
    .wr_data  (stg_data),
    .rd_ready (dllp_ready),
    .rd_valid (dllp_valid),
    .rd_data  (dllp_data),
    .level    (fifo_level),
    .overflow (overflow)
  );

endmodule

// File: doc/gen3_dllp_extractor.md
Name: gen3_dllp_extractor

Overview:
Gen3 receive stage directly downstream of the per-byte framing classifier. Consumes the 64-byte beat together with the per-byte valid_d, dlpstart and dlpend markers. Extracts each SDP-framed DLLP (8 bytes: 2-byte SDP token plus 6-byte DLLP), including DLLPs that straddle two beats. Queues them in arrival order and hands them one at a time over valid/ready to the data link layer.

Parameters:
LANES, 64, bytes per beat; must be a multiple of 8.
FIFO_DEPTH, 16, DLLP entries buffered; power of 2, at least LANES/8.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset; all state cleared while low
data_in  in  8*LANES  beat bytes, lane k = bits [8k+7:8k]
valid_in  in  LANES  per-lane byte valid (valid_d from classifier)
dlpstart  in  LANES  lane holds first SDP token byte
dlpend  in  LANES  lane holds last DLLP byte
dllp_valid  out  1  head-of-queue DLLP available
dllp_ready  in  1  consumer accepts head when dllp_valid=1
dllp_data  out  48  DLLP bytes 0..5; byte 0 in [7:0]; excludes SDP token
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries queued
overflow  out  1  sticky; set when a beat's DLLPs are dropped for lack of space
framing_err  out  1  one-cycle pulse: at least one malformed DLLP in the beat
crc_err  out  1  one-cycle pulse: CRC mismatch (see Optional Feature)

Behaviour:
- Reset values: dllp_valid=0, dllp_data=0, fifo_level=0, overflow=0, framing_err=0, crc_err=0; tail register invalid.
- Window: {current beat lanes, tail}. The tail holds the previous beat's top 7 bytes plus their valid and dlpstart bits.
- Tail update: the tail updates on any cycle with |valid_in. On an all-invalid beat the tail is retained.
- Extraction: for each lane e with dlpend[e]&valid_in[e], the DLLP is window bytes e-7..e. For e<7, the low bytes come from the tail.
- A DLLP is well-formed when all 8 bytes are valid, dlpstart is set at position e-7, byte0=8'hF0 and byte1=8'hAC.
- A malformed DLLP is discarded and framing_err pulses the next cycle.
- Markers on invalid lanes are ignored.
- Stage 1 (registered): up to LANES/8 well-formed DLLPs are compacted in ascending end-lane order, with a count.
- Stage 2: the FIFO multi-writes all staged DLLPs in one cycle, or none.
- Free-space rule: free space is evaluated before the same-cycle pop. If count > free, the whole group is dropped, overflow is set (sticky until reset) and fifo_level is unchanged.
- Latency: a DLLP ending in the beat sampled at edge N appears on dllp_valid after edge N+2 if the FIFO was empty.
- Handshake:
  - pop when dllp_valid&dllp_ready;
  - dllp_data is stable while dllp_valid&!dllp_ready;
  - a simultaneous push and pop updates fifo_level by count-1.
- Pointers wrap modulo FIFO_DEPTH. Full: no write. Empty: dllp_valid=0, and a pop request is ignored.
- If rst is asserted mid-operation, queued and staged DLLPs are discarded and the tail is invalidated.

Optional Feature:
GEN3_DLLP_CRC_CHECK_EN.
- Defined:
  - compute CRC16 (poly 16'h100B, seed 16'hFFFF, per PCIe DLLP rules) over DLLP bytes 0..3 in stage 1;
  - compare it against bytes 4..5;
  - on mismatch, discard the DLLP and pulse crc_err with framing_err timing.
- Undefined: no CRC logic; crc_err is tied 0; all well-formed DLLPs are queued.

Decomposition:
- Package gen3_rx_pkg:
  - SDP_TOKEN0=8'hF0, SDP_TOKEN1=8'hAC;
  - DLLP_BYTES=8, DLLP_PAYLOAD_BYTES=6;
  - DLLP_CRC_POLY=16'h100B, DLLP_CRC_SEED=16'hFFFF;
  - crc16_dllp function;
  - dllp_t typedef (48 bits).
- One sub-module: gen3_dllp_fifo, a multi-write (up to LANES/8), single-read queue with level output.

Test Plan:
1. Single DLLP: F0 AC 00 11 22 33 44 55 in lanes 8..15, dlpstart[8], dlpend[15], all valid -> dllp_valid after 2 edges, dllp_data=48'h554433221100, fifo_level=1 then 0 after pop.
2. Straddle: dlpstart[60] in beat A (lanes 60..63 = F0 AC 01 02), dlpend[3] in beat B (lanes 0..3 = 03 04 05 06) -> one DLLP with data 48'h060504030201, framing_err=0.
3. Eight DLLPs in one beat (ends at lanes 7,15,…,63), dllp_ready=1 -> eight outputs on consecutive cycles in lane order; level peaks at 8.
4. Overflow: dllp_ready=0; fill to 16 with two full beats; then a beat with 2 DLLPs -> overflow=1, fifo_level stays 16, and the original 16 drain intact once ready=1.
5. Framing errors: token F0 AD, or an invalid byte inside the window -> framing_err pulses once, nothing queued.
6. Macro defined: scenario 1 with byte 4 of the CRC field flipped -> crc_err pulses, no output. With a correct CRC -> crc_err stays 0.
